// File: rtl/ni_packetizer_pkg.sv
// Shared encodings for the network-interface packetizer and the routing blocks.
package ni_packetizer_pkg;

  localparam int ADDR_W    = 4;  // {y[1:0], x[1:0]}
  localparam int LEN_W     = 4;  // payload flit count, 1..15
  localparam int FLIT_ID_W = 3;

  typedef enum logic [FLIT_ID_W-1:0] {
    FLIT_HEADER = 3'b001,
    FLIT_BODY   = 3'b010,
    FLIT_TAIL   = 3'b100
  } flit_id_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HEAD_WAIT = 2'd1,
    ST_PAYLOAD   = 2'd2
  } state_e;

  // Upper bits of a header flit: payload length followed by source address.
  function automatic logic [LEN_W+ADDR_W-1:0] header_tag(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] src
  );
    return {len, src};
  endfunction

endpackage

// File: rtl/ni_packetizer_credit_counter.sv
// Downstream credit tracker: one credit per free slot in the router input FIFO.
// A return and a spend in the same cycle cancel out; a return while already
// full is dropped and latches a sticky overflow flag.
module ni_packetizer_credit_counter #(
  parameter int CREDITS = 4,
  localparam int CNT_W  = $clog2(CREDITS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  // Credit count update and sticky overflow detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= CNT_W'(CREDITS);
      overflow_q <= 1'b0;
    end else if (inc_i && !dec_i) begin
      if (count_q == CNT_W'(CREDITS)) begin
        overflow_q <= 1'b1;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ni_packetizer.sv
// Network-interface packetizer: turns a packet request plus a payload stream
// into HEADER / BODY... / TAIL flits for the local router port, gated by
// downstream credits.
//
//   state        | meaning
//   ST_IDLE      | ready for a packet request
//   ST_HEAD_WAIT | packet accepted, header held back for lack of credit
//   ST_PAYLOAD   | header sent, forwarding payload words as BODY/TAIL
module ni_packetizer
  import ni_packetizer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CREDITS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [ADDR_W-1:0]    cur_addr_i,
  input  logic                 pkt_valid_i,
  output logic                 pkt_ready_o,
  input  logic [ADDR_W-1:0]    pkt_dst_i,
  input  logic [LEN_W-1:0]     pkt_len_i,
  input  logic                 pl_valid_i,
  output logic                 pl_ready_o,
  input  logic [DATA_W-1:0]    pl_data_i,
  output logic                 tx_valid_o,
  output logic [FLIT_ID_W-1:0] tx_flit_id_o,
  output logic [ADDR_W-1:0]    tx_dst_addr_o,
  output logic [DATA_W-1:0]    tx_data_o,
  input  logic                 credit_in_i,
  output logic                 err_len_o,
  output logic                 err_credit_o
);

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam int PAD_W = DATA_W - LEN_W - ADDR_W;

  state_e                 state_q;
  logic [LEN_W-1:0]       rem_q;
  logic [ADDR_W-1:0]      dst_q;
  logic                   tx_valid_q;
  logic [FLIT_ID_W-1:0]   tx_flit_id_q;
  logic [ADDR_W-1:0]      tx_dst_q;
  logic [DATA_W-1:0]      tx_data_q;
  logic                   err_len_q;

  logic [CNT_W-1:0]       credit;
  logic                   credit_ok;
  logic                   accept;
  logic                   hdr_send;
  logic                   pl_fire;
  logic                   emit;
  logic [LEN_W-1:0]       hdr_len;
  logic [ADDR_W-1:0]      hdr_dst;
  logic [DATA_W-1:0]      hdr_word;

  assign credit_ok   = (credit != '0);
  assign pkt_ready_o = (state_q == ST_IDLE);
  assign pl_ready_o  = (state_q == ST_PAYLOAD) && credit_ok;
  assign accept      = pkt_ready_o && pkt_valid_i;
  assign pl_fire     = pl_valid_i && pl_ready_o;

  // A header leaves either straight from IDLE (request fields still on the
  // inputs) or later from HEAD_WAIT (fields taken from the latched copies).
  assign hdr_send = (accept && (pkt_len_i != '0) && credit_ok)
                  || ((state_q == ST_HEAD_WAIT) && credit_ok);
  assign emit     = hdr_send || pl_fire;
  assign hdr_len  = (state_q == ST_IDLE) ? pkt_len_i : rem_q;
  assign hdr_dst  = (state_q == ST_IDLE) ? pkt_dst_i : dst_q;
  assign hdr_word = {header_tag(hdr_len, cur_addr_i), {PAD_W{1'b0}}};

  ni_packetizer_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .inc_i      (credit_in_i),
    .dec_i      (emit),
    .count_o    (credit),
    .overflow_o (err_credit_o)
  );

  // Packet sequencing FSM with registered flit outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      dst_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_flit_id_q <= '0;
      tx_dst_q     <= '0;
      tx_data_q    <= '0;
      err_len_q    <= 1'b0;
    end else begin
      tx_valid_q <= emit;
      err_len_q  <= accept && (pkt_len_i == '0);
      if (hdr_send) begin
        tx_flit_id_q <= FLIT_HEADER;
        tx_dst_q     <= hdr_dst;
        tx_data_q    <= hdr_word;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept && (pkt_len_i != '0)) begin
            rem_q   <= pkt_len_i;
            dst_q   <= pkt_dst_i;
            state_q <= credit_ok ? ST_PAYLOAD : ST_HEAD_WAIT;
          end
        end
        ST_HEAD_WAIT: begin
          if (credit_ok) begin
            state_q <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (pl_fire) begin
            tx_flit_id_q <= (rem_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
            tx_dst_q     <= dst_q;
            tx_data_q    <= pl_data_i;
            rem_q        <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_valid_o    = tx_valid_q;
  assign tx_flit_id_o  = tx_flit_id_q;
  assign tx_dst_addr_o = tx_dst_q;
  assign tx_data_o     = tx_data_q;
  assign err_len_o     = err_len_q;

endmodule

// File: tb/tb_ni_packetizer.sv
// Bench for ni_packetizer: directed cycle table, multi-cycle corner sequences,
// then randomized traffic against a flit-queue reference model.
module tb_ni_packetizer;

  localparam int         DATA_W  = 16;
  localparam int         CREDITS = 4;
  localparam logic [3:0] MY_ADDR = 4'h5;
  localparam logic       T = 1'b1;
  localparam logic       F = 1'b0;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] B  = 3'b010;
  localparam logic [2:0] TL = 3'b100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        cur_addr = MY_ADDR;
  logic              pkt_valid, pkt_ready;
  logic [3:0]        pkt_dst, pkt_len;
  logic              pl_valid, pl_ready;
  logic [DATA_W-1:0] pl_data;
  logic              tx_valid;
  logic [2:0]        tx_flit_id;
  logic [3:0]        tx_dst_addr;
  logic [DATA_W-1:0] tx_data;
  logic              credit_in, err_len, err_credit;

  ni_packetizer #(.DATA_W(DATA_W), .CREDITS(CREDITS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cur_addr_i(cur_addr),
    .pkt_valid_i(pkt_valid), .pkt_ready_o(pkt_ready),
    .pkt_dst_i(pkt_dst), .pkt_len_i(pkt_len),
    .pl_valid_i(pl_valid), .pl_ready_o(pl_ready), .pl_data_i(pl_data),
    .tx_valid_o(tx_valid), .tx_flit_id_o(tx_flit_id),
    .tx_dst_addr_o(tx_dst_addr), .tx_data_o(tx_data),
    .credit_in_i(credit_in), .err_len_o(err_len), .err_credit_o(err_credit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [3:0]  dst;
    logic [3:0]  len;
    logic        plv;
    logic [15:0] pld;
    logic        ci;
    logic [27:0] exp;  // {txv, id, dst, data, err_len, err_credit, pkt_ready, pl_ready}
  } vec_t;

  typedef struct {
    logic [2:0]  id;
    logic [3:0]  dst;
    logic [15:0] data;
  } flit_t;

  int   total = 0;
  int   bad = 0;
  vec_t vt[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hdr(input logic [3:0] len);
    return {len, MY_ADDR, 8'h00};
  endfunction

  function automatic logic [27:0] outs();
    return {tx_valid, tx_flit_id, tx_dst_addr, tx_data, err_len, err_credit, pkt_ready, pl_ready};
  endfunction

  function automatic vec_t mk(input logic pv, input logic [3:0] dst, len, input logic plv,
                              input logic [15:0] pld, input logic ci, input logic txv,
                              input logic [2:0] id, input logic [3:0] edst,
                              input logic [15:0] edata, input logic elen, ecr, prdy, plrdy);
    vec_t v;
    v.pv = pv; v.dst = dst; v.len = len; v.plv = plv; v.pld = pld; v.ci = ci;
    v.exp = {txv, id, edst, edata, elen, ecr, prdy, plrdy};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    pkt_valid = F; pkt_dst = 4'h0; pkt_len = 4'h0;
    pl_valid = F; pl_data = 16'h0; credit_in = F;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_out", outs(), 28'h2);
    rst_n = 1'b1;
  endtask

  // Holds current inputs for a number of cycles, counting emitted flits.
  task automatic run_count(input int cycles, output int n, output logic [2:0] first_id,
                           output logic [2:0] last_id);
    n = 0; first_id = 3'b0; last_id = 3'b0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      pkt_valid = F;
      if (tx_valid) begin
        if (n == 0) first_id = tx_flit_id;
        last_id = tx_flit_id;
        n++;
      end
    end
  endtask

  initial begin
    int         n, run;
    logic [2:0] fid, lid;
    flit_t      exp_q[$];
    logic [15:0] src_q[$];
    flit_t      last, e, f;
    int         cm;
    logic       fire, nerr, drain;

    idle_in();
    do_reset();

    // Directed cycle table: basic packet, zero length, credit stall, overflow.
    vt[0]  = mk(T, 4'hA, 4'd2, F, 16'h0,    F, T, H,  4'hA, hdr(4'd2), F, F, F, T);
    vt[1]  = mk(F, 4'h0, 4'd0, T, 16'h1111, F, T, B,  4'hA, 16'h1111,  F, F, F, T);
    vt[2]  = mk(F, 4'h0, 4'd0, T, 16'h2222, F, T, TL, 4'hA, 16'h2222,  F, F, T, F);
    vt[3]  = mk(F, 4'h0, 4'd0, F, 16'h0,    F, F, TL, 4'hA, 16'h2222,  F, F, T, F);
    vt[4]  = mk(T, 4'h3, 4'd0, F, 16'h0,    F, F, TL, 4'hA, 16'h2222,  T, F, T, F);
    vt[5]  = mk(T, 4'h5, 4'd2, F, 16'h0,    F, T, H,  4'h5, hdr(4'd2), F, F, F, F);
    vt[6]  = mk(F, 4'h0, 4'd0, T, 16'h3333, F, F, H,  4'h5, hdr(4'd2), F, F, F, F);
    vt[7]  = mk(F, 4'h0, 4'd0, T, 16'h3333, T, F, H,  4'h5, hdr(4'd2), F, F, F, T);
    vt[8]  = mk(F, 4'h0, 4'd0, T, 16'h3333, F, T, B,  4'h5, 16'h3333,  F, F, F, F);
    vt[9]  = mk(F, 4'h0, 4'd0, F, 16'h0,    T, F, B,  4'h5, 16'h3333,  F, F, F, T);
    vt[10] = mk(F, 4'h0, 4'd0, F, 16'h0,    T, F, B,  4'h5, 16'h3333,  F, F, F, T);
    vt[11] = mk(F, 4'h0, 4'd0, F, 16'h0,    T, F, B,  4'h5, 16'h3333,  F, F, F, T);
    vt[12] = mk(F, 4'h0, 4'd0, F, 16'h0,    T, F, B,  4'h5, 16'h3333,  F, F, F, T);
    vt[13] = mk(F, 4'h0, 4'd0, F, 16'h0,    T, F, B,  4'h5, 16'h3333,  F, T, F, T);
    vt[14] = mk(F, 4'h0, 4'd0, T, 16'h4444, F, T, TL, 4'h5, 16'h4444,  F, T, T, F);
    vt[15] = mk(F, 4'h0, 4'd0, F, 16'h0,    F, F, TL, 4'h5, 16'h4444,  F, T, T, F);
    for (int i = 0; i < 16; i++) begin
      pkt_valid = vt[i].pv; pkt_dst = vt[i].dst; pkt_len = vt[i].len;
      pl_valid = vt[i].plv; pl_data = vt[i].pld; credit_in = vt[i].ci;
      tick();
      check($sformatf("vec%0d", i), outs(), vt[i].exp);
    end

    // Reset in the middle of a packet, right after the second BODY flit.
    do_reset();
    pkt_valid = T; pkt_dst = 4'h9; pkt_len = 4'd6; pl_valid = T; pl_data = 16'hA5A5;
    n = 0;
    for (int c = 0; c < 12 && n < 3; c++) begin
      tick();
      pkt_valid = F;
      if (tx_valid) n++;
    end
    check("midpkt_reach", n, 3);
    idle_in();
    rst_n = 1'b0;
    #1;
    check("midpkt_rst", outs(), 28'h2);
    @(negedge clk);
    rst_n = 1'b1;

    // Full credit after reset: 4 flits then stall; one credit -> one more flit.
    pkt_valid = T; pkt_dst = 4'h7; pkt_len = 4'd6; pl_valid = T; pl_data = 16'hB0B0;
    run_count(12, n, fid, lid);
    check("stall_flits", n, 4);
    check("stall_first_hdr", fid, H);
    check("stall_plrdy", pl_ready, F);
    credit_in = T;
    tick();
    credit_in = F;
    run_count(8, n, fid, lid);
    check("one_credit_flits", n, 1);
    check("one_credit_id", lid, B);

    // Accept with no credit: header held in HEAD_WAIT until a credit returns.
    do_reset();
    pkt_valid = T; pkt_dst = 4'h2; pkt_len = 4'd3; pl_valid = T; pl_data = 16'hC0C0;
    run_count(8, n, fid, lid);
    check("drain_flits", n, 4);
    check("drain_idle", pkt_ready, T);
    pkt_valid = T; pkt_dst = 4'h4; pkt_len = 4'd1;
    tick();
    pkt_valid = F;
    check("hw_enter", {tx_valid, pkt_ready}, 2'b00);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hw_hold", tx_valid, F);
    end
    credit_in = T;
    tick();
    credit_in = F;
    check("hw_ci_edge", tx_valid, F);
    tick();
    check("hw_hdr", {tx_valid, tx_flit_id, tx_dst_addr, tx_data}, {T, H, 4'h4, hdr(4'd1)});

    // Credit returned alongside every flit: 16 back-to-back flits, count constant.
    do_reset();
    pkt_valid = T; pkt_dst = 4'hC; pkt_len = 4'd15; credit_in = T;
    tick();
    pkt_valid = F;
    run = tx_valid ? 1 : 0;
    pl_valid = T;
    for (int k = 0; k < 15; k++) begin
      pl_data = 16'(16'hD000 + k);
      tick();
      if (tx_valid) run++;
    end
    check("b2b_run", run, 16);
    check("b2b_tail", tx_flit_id, TL);
    credit_in = F; pl_valid = F;
    tick();
    check("b2b_no_ovf", err_credit, F);
    pkt_valid = T; pkt_dst = 4'h1; pkt_len = 4'd3; pl_valid = T;
    run_count(8, n, fid, lid);
    check("b2b_credit_full", n, 4);
    check("b2b_idle", pkt_ready, T);

    // Randomized traffic against a flit-queue model with credit accounting.
    do_reset();
    cm = CREDITS;
    last.id = 3'b0; last.dst = 4'h0; last.data = 16'h0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      drain = (cyc >= 3000);
      if (drain && exp_q.size() == 0 && src_q.size() == 0) break;
      pkt_valid = !drain && pkt_ready && ($urandom_range(0, 3) == 0);
      pkt_dst = 4'($urandom);
      pkt_len = 4'($urandom_range(0, 15));
      nerr = pkt_valid && (pkt_len == 4'd0);
      if (pkt_valid && pkt_len != 4'd0) begin
        f.id = H; f.dst = pkt_dst; f.data = hdr(pkt_len);
        exp_q.push_back(f);
        for (int i = 0; i < int'(pkt_len); i++) begin
          f.id = (i == int'(pkt_len) - 1) ? TL : B;
          f.data = 16'($urandom);
          src_q.push_back(f.data);
          exp_q.push_back(f);
        end
      end
      pl_valid = (src_q.size() != 0) && ($urandom_range(0, 3) != 0);
      pl_data = pl_valid ? src_q[0] : 16'($urandom);
      credit_in = (cm < CREDITS) && ($urandom_range(0, 2) == 0);
      check("rnd_plrdy_nocredit", pl_ready && (cm == 0), F);
      fire = pl_valid && pl_ready;
      tick();
      if (fire) void'(src_q.pop_front());
      if (tx_valid) begin
        check("rnd_credit_avail", cm > 0, T);
        check("rnd_expected_flit", exp_q.size() != 0, T);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rnd_flit", {tx_flit_id, tx_dst_addr, tx_data}, {e.id, e.dst, e.data});
          last = e;
        end
      end else begin
        check("rnd_hold", {tx_flit_id, tx_dst_addr, tx_data}, {last.id, last.dst, last.data});
      end
      cm = cm + int'(credit_in) - int'(tx_valid);
      check("rnd_err_len", err_len, nerr);
      check("rnd_err_credit", err_credit, F);
    end
    check("rnd_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
